// File: rtl/desync_pkg.sv
// Shared async-link definitions: encodings, dual-rail rail indices and FSM states.
package desync_pkg;

  localparam int RAIL_NUM = 2;
  localparam int RAIL_T   = 1;
  localparam int RAIL_F   = 0;

  typedef enum logic {
    ENC_TP,
    ENC_FP
  } enc_e;

  typedef enum logic [1:0] {
    FP_IDLE,
    FP_DATA,
    FP_RTZ
  } fp_state_e;

  typedef enum logic {
    TP_IDLE,
    TP_WAIT
  } tp_state_e;

  // Encoding names are two-character strings packed into 16 bits.
  function automatic logic enc_ok(input logic [15:0] s);
    return (s == "TP") || (s == "FP");
  endfunction

  function automatic enc_e enc_from_str(input logic [15:0] s);
    return (s == "FP") ? ENC_FP : ENC_TP;
  endfunction

endpackage

// File: rtl/desync_if.sv
// Word-side valid/ready bus plus dual-rail link and receiver acknowledge.
interface desync_if #(
  parameter int WIDTH = 8
);
  import desync_pkg::*;

  logic [WIDTH-1:0]               in;
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0][RAIL_NUM-1:0] out;
  logic                           ack_i;
  logic                           err;

  modport master (
    output in, in_valid, ack_i,
    input  in_ready, out, err
  );

  modport slave (
    input  in, in_valid, ack_i,
    output in_ready, out, err
  );

endinterface

// File: rtl/desync_flop_sync.sv
// Single-bit multi-flop synchronizer with async active-low reset.
module flop_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/desync.sv
// Clocked-to-async transmitter: one valid/ready word becomes one dual-rail token (TP or FP).
// Optional ack watchdog enabled by defining DESYNC_ACK_TIMEOUT_EN.
module desync #(
  parameter int          WIDTH       = 8,
  parameter int          RAIL_NUM    = 2,
  parameter logic [15:0] ENC         = "TP",
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 1024
) (
  input logic     clk,
  input logic     rst,
  desync_if.slave bus
);
  import desync_pkg::*;

  localparam enc_e ENC_SEL = enc_from_str(ENC);

  if (RAIL_NUM != 2) begin : g_bad_rail
    $error("desync: RAIL_NUM must be 2");
  end
  if (!enc_ok(ENC)) begin : g_bad_enc
    $error("desync: ENC must be \"TP\" or \"FP\"");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("desync: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("desync: TIMEOUT must be at least 2");
  end

  logic ack_s;
  logic ready_en_q;
  logic idle;
  logic ready_gate;
  logic wait_st;
  logic st_chg;
  logic in_ready;
  logic accept;
  logic [WIDTH-1:0][RAIL_NUM-1:0] out_q;

  flop_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (bus.ack_i),
    .q_o   (ack_s)
  );

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  assign in_ready     = ready_en_q & idle & ready_gate;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;
  assign bus.out      = out_q;

  if (ENC_SEL == ENC_FP) begin : g_fp
    fp_state_e st_q, st_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= FP_IDLE;
        out_q <= '0;
      end else begin
        st_q  <= st_d;
        out_q <= out_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      out_d = out_q;
      case (st_q)
        FP_IDLE: begin
          if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
              out_d[i][RAIL_T] = bus.in[i];
              out_d[i][RAIL_F] = ~bus.in[i];
            end
            st_d = FP_DATA;
          end
        end
        FP_DATA: begin
          if (ack_s) begin
            out_d = '0;
            st_d  = FP_RTZ;
          end
        end
        FP_RTZ: begin
          if (!ack_s) st_d = FP_IDLE;
        end
        default: st_d = FP_IDLE;
      endcase
    end

    // A stale high ack in IDLE still blocks acceptance until it returns to zero.
    assign idle       = (st_q == FP_IDLE);
    assign ready_gate = ~ack_s;
    assign wait_st    = (st_q != FP_IDLE);
    assign st_chg     = (st_d != st_q);
  end else begin : g_tp
    tp_state_e st_q, st_d;
    logic phase_q, phase_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q    <= TP_IDLE;
        phase_q <= 1'b0;
        out_q   <= '0;
      end else begin
        st_q    <= st_d;
        phase_q <= phase_d;
        out_q   <= out_d;
      end
    end

    always_comb begin
      st_d    = st_q;
      phase_d = phase_q;
      out_d   = out_q;
      case (st_q)
        TP_IDLE: begin
          if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
              out_d[i][RAIL_T] = out_q[i][RAIL_T] ^ bus.in[i];
              out_d[i][RAIL_F] = out_q[i][RAIL_F] ^ ~bus.in[i];
            end
            st_d = TP_WAIT;
          end
        end
        TP_WAIT: begin
          if (ack_s != phase_q) begin
            phase_d = ~phase_q;
            st_d    = TP_IDLE;
          end
        end
        default: st_d = TP_IDLE;
      endcase
    end

    assign idle       = (st_q == TP_IDLE);
    assign ready_gate = 1'b1;
    assign wait_st    = (st_q == TP_WAIT);
    assign st_chg     = (st_d != st_q);
  end

`ifdef DESYNC_ACK_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter restarts on every state change and saturates at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (st_chg) begin
      cnt_d = '0;
    end else if (wait_st && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wait_st && (cnt_q == CNT_MAX)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_wait;
  assign unused_wait = wait_st ^ st_chg;
  assign bus.err     = 1'b0;
`endif

endmodule
